// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: opcode encodings, condition-code
// bit positions, the multiplier FSM state type and a CC helper.
package execute_stage_pkg;

  localparam int REG_WIDTH    = 16;
  localparam int PC_WIDTH     = 16;
  localparam int OPCODE_WIDTH = 8;

  // Opcode encodings shared with decode and memory
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 8'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 8'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 8'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = 8'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = 8'h05;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI = 8'h06;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW  = 8'h07;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW  = 8'h08;
  localparam logic [OPCODE_WIDTH-1:0] OP_BR   = 8'h09;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 8'h0A;
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR  = 8'h0B;
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = 8'h0C;

  // Condition-code bit positions inside the 3-bit NZP register
  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  // Iterative multiplier states
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // NZP value for a result given its sign bit and zero flag
  function automatic logic [2:0] cc_from(input logic msb, input logic is_zero);
    logic [2:0] cc;
    cc = 3'b000;
    if (is_zero)  cc[CC_Z] = 1'b1;
    else if (msb) cc[CC_N] = 1'b1;
    else          cc[CC_P] = 1'b1;
    return cc;
  endfunction

endpackage

// File: rtl/execute_stage_mul.sv
// Iterative shift-add multiplier: one partial product per cycle for DATA_W
// cycles, then a single DONE cycle in which result is valid.
// Handshake: start is honoured only in IDLE with en high; busy is high in
// RUN and DONE; done is high only in DONE. en low freezes every register.
module iter_mul
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  mul_state_e        state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;

  assign busy      = (state != MUL_IDLE);
  assign done      = (state == MUL_DONE);
  assign result    = acc;
  assign state_dbg = state;

  // FSM plus datapath; updates on the falling edge like the rest of the pipe
  always_ff @(negedge clk) begin
    if (reset) begin
      state  <= MUL_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (en) begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CNT_W'(DATA_W - 1);
            state  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) state <= MUL_DONE;
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, NZP condition codes, branch resolution and the
// registered bundle handed to the memory stage. MUL runs in iter_mul and
// stalls upstream (O_ExStall) from acceptance until its result is emitted.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = REG_WIDTH,
  parameter int PC_W   = PC_WIDTH,
  parameter int OPC_W  = OPCODE_WIDTH
) (
  input  logic              I_CLOCK,
  input  logic              I_RESET,
  input  logic              I_LOCK,
  input  logic [OPC_W-1:0]  I_Opcode,
  input  logic [DATA_W-1:0] I_Src1Value,
  input  logic [DATA_W-1:0] I_Src2Value,
  input  logic [DATA_W-1:0] I_Imm,
  input  logic [PC_W-1:0]   I_PC,
  input  logic [2:0]        I_CondMask,
  input  logic [3:0]        I_DestRegIdx,
  input  logic              I_FetchStall,
  input  logic              I_DepStall,
  output logic              O_LOCK,
  output logic [DATA_W-1:0] O_ALUOut,
  output logic [OPC_W-1:0]  O_Opcode,
  output logic [3:0]        O_DestRegIdx,
  output logic [DATA_W-1:0] O_DestValue,
  output logic [PC_W-1:0]   O_BranchPC,
  output logic              O_BranchTaken,
  output logic              O_FetchStall,
  output logic              O_DepStall,
  output logic              O_ExStall
);

  logic [2:0]        cc;
  logic              bubble;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_result;
  logic [3:0]        mul_dest;

  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] nxt_alu;
  logic [OPC_W-1:0]  nxt_opc;
  logic [3:0]        nxt_dest;
  logic [DATA_W-1:0] nxt_dval;
  logic [PC_W-1:0]   nxt_bpc;
  logic              nxt_taken;
  logic              cc_wr;
  logic [2:0]        nxt_cc;

  assign bubble    = !I_LOCK || I_FetchStall || I_DepStall;
  assign mul_start = !mul_busy && !bubble && (I_Opcode == OP_MUL);
  assign O_ExStall = mul_busy;

  iter_mul #(.DATA_W(DATA_W)) u_mul (
    .clk       (I_CLOCK),
    .reset     (I_RESET),
    .en        (I_LOCK),
    .start     (mul_start),
    .a         (I_Src1Value),
    .b         (I_Src2Value),
    .busy      (mul_busy),
    .done      (mul_done),
    .result    (mul_result),
    .state_dbg ()
  );

  // Destination index travels with the multiply, independent of the inputs
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET)        mul_dest <= '0;
    else if (mul_start) mul_dest <= I_DestRegIdx;
  end

  // Next output bundle: MUL result, a single-cycle op, or a bubble
  always_comb begin
    res       = '0;
    nxt_alu   = '0;
    nxt_opc   = OP_NOP;
    nxt_dest  = '0;
    nxt_dval  = '0;
    nxt_bpc   = '0;
    nxt_taken = 1'b0;
    cc_wr     = 1'b0;
    if (mul_done && I_LOCK) begin
      res      = mul_result;
      nxt_alu  = res;
      nxt_opc  = OP_MUL;
      nxt_dest = mul_dest;
      cc_wr    = 1'b1;
    end else if (!mul_busy && !bubble) begin
      nxt_dest = I_DestRegIdx;
      case (I_Opcode)
        OP_ADD:  begin res = I_Src1Value + I_Src2Value; nxt_alu = res; nxt_opc = I_Opcode; cc_wr = 1'b1; end
        OP_ADDI: begin res = I_Src1Value + I_Imm;       nxt_alu = res; nxt_opc = I_Opcode; cc_wr = 1'b1; end
        OP_AND:  begin res = I_Src1Value & I_Src2Value; nxt_alu = res; nxt_opc = I_Opcode; cc_wr = 1'b1; end
        OP_ANDI: begin res = I_Src1Value & I_Imm;       nxt_alu = res; nxt_opc = I_Opcode; cc_wr = 1'b1; end
        OP_MOV:  begin res = I_Src1Value;               nxt_alu = res; nxt_opc = I_Opcode; cc_wr = 1'b1; end
        OP_MOVI: begin res = I_Imm;                     nxt_alu = res; nxt_opc = I_Opcode; cc_wr = 1'b1; end
        OP_LDW: begin
          nxt_alu = I_Src1Value + I_Imm;
          nxt_opc = I_Opcode;
        end
        OP_STW: begin
          nxt_alu  = I_Src1Value + I_Imm;
          nxt_dval = I_Src2Value;
          nxt_opc  = I_Opcode;
        end
        OP_BR: begin
          nxt_opc   = I_Opcode;
          nxt_bpc   = I_PC + I_Imm[PC_W-1:0];
          nxt_taken = |(I_CondMask & cc);
        end
        OP_JMP: begin
          nxt_opc   = I_Opcode;
          nxt_bpc   = I_Src1Value[PC_W-1:0];
          nxt_taken = 1'b1;
        end
        OP_JSR: begin
          nxt_opc   = I_Opcode;
          nxt_bpc   = I_PC + I_Imm[PC_W-1:0];
          nxt_taken = 1'b1;
          nxt_alu   = DATA_W'(I_PC);
          nxt_dest  = 4'd7;
        end
        // OP_MUL produces its result later; unknown opcodes become bubbles
        default: nxt_dest = '0;
      endcase
    end
    nxt_cc = cc_from(res[DATA_W-1], res == '0);
  end

  // Output bundle and condition-code register
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      O_LOCK        <= 1'b0;
      O_ALUOut      <= '0;
      O_Opcode      <= OP_NOP;
      O_DestRegIdx  <= '0;
      O_DestValue   <= '0;
      O_BranchPC    <= '0;
      O_BranchTaken <= 1'b0;
      O_FetchStall  <= 1'b0;
      O_DepStall    <= 1'b0;
      cc            <= 3'b010;
    end else begin
      O_LOCK        <= I_LOCK;
      O_ALUOut      <= nxt_alu;
      O_Opcode      <= nxt_opc;
      O_DestRegIdx  <= nxt_dest;
      O_DestValue   <= nxt_dval;
      O_BranchPC    <= nxt_bpc;
      O_BranchTaken <= nxt_taken;
      O_FetchStall  <= I_FetchStall;
      O_DepStall    <= I_DepStall;
      if (cc_wr) cc <= nxt_cc;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed vectors, immediate
// assertions at each check point, one summary line at the end.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        I_CLOCK = 1'b0;
  logic        I_RESET;
  logic        I_LOCK;
  logic [7:0]  I_Opcode;
  logic [15:0] I_Src1Value, I_Src2Value, I_Imm, I_PC;
  logic [2:0]  I_CondMask;
  logic [3:0]  I_DestRegIdx;
  logic        I_FetchStall, I_DepStall;
  logic        O_LOCK;
  logic [15:0] O_ALUOut;
  logic [7:0]  O_Opcode;
  logic [3:0]  O_DestRegIdx;
  logic [15:0] O_DestValue;
  logic [15:0] O_BranchPC;
  logic        O_BranchTaken, O_FetchStall, O_DepStall, O_ExStall;

  int checks   = 0;
  int failures = 0;

  execute_stage dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_Opcode(I_Opcode),
    .I_Src1Value(I_Src1Value), .I_Src2Value(I_Src2Value), .I_Imm(I_Imm), .I_PC(I_PC),
    .I_CondMask(I_CondMask), .I_DestRegIdx(I_DestRegIdx),
    .I_FetchStall(I_FetchStall), .I_DepStall(I_DepStall),
    .O_LOCK(O_LOCK), .O_ALUOut(O_ALUOut), .O_Opcode(O_Opcode), .O_DestRegIdx(O_DestRegIdx),
    .O_DestValue(O_DestValue), .O_BranchPC(O_BranchPC), .O_BranchTaken(O_BranchTaken),
    .O_FetchStall(O_FetchStall), .O_DepStall(O_DepStall), .O_ExStall(O_ExStall)
  );

  // Clock: falling edges at 10, 20, 30 ...
  always #5 I_CLOCK = ~I_CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one stage cycle and sample 1 time unit after the active edge
  task automatic step();
    @(negedge I_CLOCK);
    #1;
  endtask

  task automatic drive(input logic [7:0] opc, input logic [15:0] s1, input logic [15:0] s2,
                       input logic [15:0] imm, input logic [15:0] pc, input logic [2:0] mask,
                       input logic [3:0] dest);
    I_LOCK = 1'b1; I_Opcode = opc; I_Src1Value = s1; I_Src2Value = s2;
    I_Imm = imm; I_PC = pc; I_CondMask = mask; I_DestRegIdx = dest;
  endtask

  // Branch probe of the current CC: drive BR with a mask, check taken
  task automatic cc_probe(input string tag, input logic [2:0] mask, input logic exp_taken);
    drive(OP_BR, 16'h0, 16'h0, 16'h0002, 16'h0100, mask, 4'd0);
    step();
    chk(tag, O_BranchTaken, exp_taken);
  endtask

  // Run an already-accepted MUL to completion; inputs stay stable meanwhile.
  // Lock is dropped for three cycles starting at cycle freeze_at.
  task automatic run_mul(input string tag, input int freeze_at, input int exp_cycles,
                         input logic [15:0] exp_res, input logic [3:0] exp_dest);
    int n = 0;
    int bad = 0;
    while (O_ExStall === 1'b1 && n < 60) begin
      if (O_Opcode !== OP_NOP) bad++;
      I_LOCK = !(n >= freeze_at && n < freeze_at + 3);
      step();
      n++;
    end
    I_LOCK = 1'b1;
    chk({tag, "_stall_cycles"}, n, exp_cycles);
    chk({tag, "_bubbles"}, bad, 0);
    chk({tag, "_opc"}, O_Opcode, OP_MUL);
    chk({tag, "_res"}, O_ALUOut, exp_res);
    chk({tag, "_dest"}, O_DestRegIdx, exp_dest);
  endtask

  initial begin
    int seen_mul;
    I_RESET = 1'b1; I_FetchStall = 1'b0; I_DepStall = 1'b0;
    drive(OP_NOP, 0, 0, 0, 0, 3'b000, 0);
    I_LOCK = 1'b0;
    step(); step();
    chk("rst_opc", O_Opcode, OP_NOP);
    chk("rst_lock", O_LOCK, 0);
    chk("rst_alu", O_ALUOut, 0);
    chk("rst_dest", O_DestRegIdx, 0);
    chk("rst_dval", O_DestValue, 0);
    chk("rst_bpc", O_BranchPC, 0);
    chk("rst_taken", O_BranchTaken, 0);
    chk("rst_exstall", O_ExStall, 0);
    I_RESET = 1'b0;
    step();
    chk("idle_opc", O_Opcode, OP_NOP);
    cc_probe("rst_cc_z", 3'b010, 1'b1);
    chk("br_bpc", O_BranchPC, 16'h0102);
    chk("br_lock", O_LOCK, 1);

    // ADDI wraps to zero, branch with negative offset
    drive(OP_ADDI, 16'hFFFF, 16'h0, 16'h0001, 16'h0, 3'b000, 4'd3);
    step();
    chk("addi_alu", O_ALUOut, 16'h0000);
    chk("addi_opc", O_Opcode, OP_ADDI);
    chk("addi_dest", O_DestRegIdx, 4'd3);
    drive(OP_BR, 16'h0, 16'h0, 16'hFFFE, 16'h0010, 3'b010, 4'd0);
    step();
    chk("br_neg_taken", O_BranchTaken, 1);
    chk("br_neg_bpc", O_BranchPC, 16'h000E);
    cc_probe("addi_cc_not_np", 3'b101, 1'b0);

    // ADD -> positive, AND -> negative, MOVI, MOV
    drive(OP_ADD, 16'h0003, 16'h0004, 16'h0, 16'h0, 3'b000, 4'd2);
    step();
    chk("add_alu", O_ALUOut, 16'h0007);
    cc_probe("add_cc_p", 3'b001, 1'b1);
    drive(OP_AND, 16'hF0F0, 16'h8F00, 16'h0, 16'h0, 3'b000, 4'd1);
    step();
    chk("and_alu", O_ALUOut, 16'h8000);
    cc_probe("and_cc_n", 3'b100, 1'b1);
    cc_probe("and_cc_not_zp", 3'b011, 1'b0);
    drive(OP_ANDI, 16'h00FF, 16'h0, 16'h0F0F, 16'h0, 3'b000, 4'd1);
    step();
    chk("andi_alu", O_ALUOut, 16'h000F);
    drive(OP_MOVI, 16'h0, 16'h0, 16'h1234, 16'h0, 3'b000, 4'd5);
    step();
    chk("movi_alu", O_ALUOut, 16'h1234);
    drive(OP_MOV, 16'h0000, 16'h0, 16'h5555, 16'h0, 3'b000, 4'd5);
    step();
    chk("mov_alu", O_ALUOut, 16'h0000);
    cc_probe("mov_cc_z", 3'b010, 1'b1);

    // Jumps
    drive(OP_JMP, 16'h0400, 16'h0, 16'h0, 16'h0, 3'b000, 4'd0);
    step();
    chk("jmp_taken", O_BranchTaken, 1);
    chk("jmp_bpc", O_BranchPC, 16'h0400);
    drive(OP_JSR, 16'h0, 16'h0, 16'h0010, 16'h0050, 3'b000, 4'd2);
    step();
    chk("jsr_bpc", O_BranchPC, 16'h0060);
    chk("jsr_alu", O_ALUOut, 16'h0050);
    chk("jsr_dest", O_DestRegIdx, 4'd7);

    // MUL 0x0123 * 0x0045 = 0x4E6F
    drive(OP_MUL, 16'h0123, 16'h0045, 16'h0, 16'h0, 3'b000, 4'd6);
    step();
    chk("mula_accept", O_ExStall, 1);
    run_mul("mula", 1000, 17, 16'h4E6F, 4'd6);
    chk("mula_exstall_low", O_ExStall, 0);
    cc_probe("mula_cc_p", 3'b001, 1'b1);
    cc_probe("mula_cc_not_nz", 3'b110, 1'b0);

    // MUL 0x8000 * 2 wraps to 0, with three locked-out cycles in the middle
    drive(OP_MUL, 16'h8000, 16'h0002, 16'h0, 16'h0, 3'b000, 4'd4);
    step();
    run_mul("mulb", 4, 20, 16'h0000, 4'd4);
    cc_probe("mulb_cc_z", 3'b010, 1'b1);

    // Back-to-back MULs: the second is accepted right after the first result
    drive(OP_MUL, 16'h0003, 16'h0005, 16'h0, 16'h0, 3'b000, 4'd1);
    step();
    run_mul("mulc", 1000, 17, 16'h000F, 4'd1);
    drive(OP_MUL, 16'h00FF, 16'h0101, 16'h0, 16'h0, 3'b000, 4'd2);
    step();
    chk("muld_accept", O_ExStall, 1);
    run_mul("muld", 1000, 17, 16'hFFFF, 4'd2);
    cc_probe("muld_cc_n", 3'b100, 1'b1);

    // Reset five cycles into a MUL discards it
    drive(OP_MUL, 16'h0007, 16'h0007, 16'h0, 16'h0, 3'b000, 4'd3);
    step();
    repeat (5) step();
    chk("mule_busy", O_ExStall, 1);
    I_RESET = 1'b1;
    step();
    I_RESET = 1'b0;
    chk("mule_rst_exstall", O_ExStall, 0);
    chk("mule_rst_opc", O_Opcode, OP_NOP);
    I_LOCK = 1'b0;
    seen_mul = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (O_Opcode === OP_MUL) seen_mul++;
    end
    chk("mule_no_result", seen_mul, 0);
    cc_probe("mule_cc_z", 3'b010, 1'b1);

    // Dependency stall turns ADD into a bubble and leaves CC alone
    drive(OP_ADD, 16'h0001, 16'h0001, 16'h0, 16'h0, 3'b000, 4'd2);
    I_DepStall = 1'b1;
    step();
    chk("dep_opc", O_Opcode, OP_NOP);
    chk("dep_flag", O_DepStall, 1);
    chk("dep_lock", O_LOCK, 1);
    I_DepStall = 1'b0;
    cc_probe("dep_cc_z", 3'b010, 1'b1);
    drive(OP_ADD, 16'h0001, 16'h0001, 16'h0, 16'h0, 3'b000, 4'd2);
    I_FetchStall = 1'b1;
    step();
    chk("fetch_opc", O_Opcode, OP_NOP);
    chk("fetch_flag", O_FetchStall, 1);
    I_FetchStall = 1'b0;

    // Memory ops
    drive(OP_STW, 16'h0100, 16'hBEEF, 16'h0004, 16'h0, 3'b000, 4'd0);
    step();
    chk("stw_alu", O_ALUOut, 16'h0104);
    chk("stw_dval", O_DestValue, 16'hBEEF);
    chk("stw_opc", O_Opcode, OP_STW);
    drive(OP_LDW, 16'h2000, 16'h1111, 16'hFFFC, 16'h0, 3'b000, 4'd4);
    step();
    chk("ldw_alu", O_ALUOut, 16'h1FFC);
    chk("ldw_dval", O_DestValue, 16'h0000);
    cc_probe("ldw_cc_unchanged", 3'b010, 1'b1);

    // Unknown opcode is a bubble
    drive(8'hFF, 16'h1234, 16'h0, 16'h0, 16'h0, 3'b000, 4'd2);
    step();
    chk("unk_opc", O_Opcode, OP_NOP);
    chk("unk_alu", O_ALUOut, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
